apb_regfile_slave: RTL and testbench

//  Parametrised APB slave: register file of NUM_REGS words, configurable wait states, error response.

---
 rtl/apb_regfile_slave.sv | 148 ++++++++++++++
 tb/tb_apb_regfile_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB CSR bank of NUM_REGS words with configurable wait states and SLVERR.
// Optional byte-strobe writes under macro APB_PSTRB_EN.  Rev 1.0
`default_nettype none

module apb_regfile_slave #(
  parameter int                 A_WIDTH     = 8,
  parameter int                 D_WIDTH     = 8,
  parameter int                 NUM_REGS    = 16,
  parameter int                 WAIT_STATES = 1,
  parameter logic [D_WIDTH-1:0] RESET_VAL   = 'h12
) (
  input  logic               p_clk,
  input  logic               p_rstn,
  input  logic               p_sel,
  input  logic               p_enable,
  input  logic               p_write,
  input  logic [A_WIDTH-1:0] p_addr,
  input  logic [D_WIDTH-1:0] wr_data,
`ifdef APB_PSTRB_EN
  input  logic [D_WIDTH/8-1:0] p_strb,
`endif
  output logic [D_WIDTH-1:0] rd_data,
  output logic               p_ready,
  output logic               p_slverr,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_WPHASE = 2'd2,
    S_RPHASE = 2'd3
  } state_t;

  localparam logic [3:0]       c_wait = 4'(WAIT_STATES);
  localparam logic [A_WIDTH:0] c_num  = (A_WIDTH+1)'(NUM_REGS);

  state_t             r_state;
  logic [3:0]         r_wait_cnt;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [D_WIDTH-1:0] r_rd_data;
  logic [D_WIDTH-1:0] r_mem [NUM_REGS];

  logic               w_in_phase;
  logic               w_ready;
  logic               w_valid;
  logic               w_commit;
  logic [D_WIDTH-1:0] w_wmask;
  logic [D_WIDTH-1:0] w_rd_word;

`ifdef APB_PSTRB_EN
  logic [D_WIDTH/8-1:0] r_strb;

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < D_WIDTH/8; i++) begin
      w_wmask[i*8 +: 8] = {8{r_strb[i]}};
    end
  end

  always_ff @(posedge p_clk) begin
    if (!p_rstn) begin
      r_strb <= '0;
    end else if (r_state == S_SETUP && p_sel) begin
      r_strb <= p_strb;
    end
  end
`else
  assign w_wmask = '1;
`endif

  assign w_in_phase = (r_state == S_WPHASE) || (r_state == S_RPHASE);
  assign w_ready    = w_in_phase && p_sel && p_enable && (r_wait_cnt == c_wait);
  assign w_valid    = ({1'b0, r_addr} < c_num);
  assign w_commit   = w_ready && (r_state == S_WPHASE) && w_valid;

  assign p_ready  = w_ready;
  assign p_slverr = w_ready && !w_valid;
  assign rd_data  = r_rd_data;
  assign state    = r_state;

  // Read data is sampled from the live bus address as SETUP exits; misses read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (p_addr == A_WIDTH'(i)) begin
        w_rd_word = r_mem[i];
      end
    end
  end

  always_ff @(posedge p_clk) begin
    if (!p_rstn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= RESET_VAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (p_sel) r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (!p_sel) begin
            r_state <= S_IDLE;
          end else begin
            r_addr     <= p_addr;
            r_wdata    <= wr_data;
            r_wait_cnt <= '0;
            if (p_write) begin
              r_state <= S_WPHASE;
            end else begin
              r_state   <= S_RPHASE;
              r_rd_data <= w_rd_word;
            end
          end
        end
        default: begin
          if (!p_sel) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
          end else if (w_ready) begin
            r_state <= S_SETUP;
          end else if (p_enable && (r_wait_cnt < c_wait)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge p_clk) begin
    if (!p_rstn) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && (r_addr == A_WIDTH'(i))) begin
          r_mem[i] <= (r_mem[i] & ~w_wmask) | (r_wdata & w_wmask);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed APB transfers with a queue-based completion scoreboard.
`default_nettype none

module tb_apb_regfile_slave;

`ifdef APB_PSTRB_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int AW = 8;
  localparam int SW = DW/8;

  typedef struct packed {
    logic          err;
    logic          is_rd;
    logic [DW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sel, en, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] strb;
  logic [DW-1:0] rd;
  logic          ready, err;
  logic [1:0]    st;

  logic          b_sel, b_en, b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [SW-1:0] b_strb;
  logic [DW-1:0] b_rd;
  logic          b_ready, b_err;
  logic [1:0]    b_st;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t m_e;

  always #10 clk = ~clk;

  apb_regfile_slave #(.A_WIDTH(AW), .D_WIDTH(DW), .NUM_REGS(16), .WAIT_STATES(1),
                      .RESET_VAL(DW'('h12))) u_dut (
    .p_clk(clk), .p_rstn(rstn), .p_sel(sel), .p_enable(en), .p_write(wr),
    .p_addr(addr), .wr_data(wdata),
`ifdef APB_PSTRB_EN
    .p_strb(strb),
`endif
    .rd_data(rd), .p_ready(ready), .p_slverr(err), .state(st)
  );

  apb_regfile_slave #(.A_WIDTH(AW), .D_WIDTH(DW), .NUM_REGS(16), .WAIT_STATES(0),
                      .RESET_VAL(DW'('h12))) u_dut0 (
    .p_clk(clk), .p_rstn(rstn), .p_sel(b_sel), .p_enable(b_en), .p_write(b_wr),
    .p_addr(b_addr), .wr_data(b_wdata),
`ifdef APB_PSTRB_EN
    .p_strb(b_strb),
`endif
    .rd_data(b_rd), .p_ready(b_ready), .p_slverr(b_err), .state(b_st)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every p_ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        m_e = q.pop_front();
        chk("slverr", 32'(err), 32'(m_e.err));
        if (m_e.is_rd) chk("rd_data", 32'(rd), 32'(m_e.rd));
      end
    end
  end

  task automatic apb_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic exp_err, input logic [DW-1:0] exp_rd);
    exp_t e;
    int   waits;
    bit   done;
    e.err = exp_err; e.is_rd = !w; e.rd = exp_rd;
    q.push_back(e);
    @(posedge clk); #1;
    sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d; strb = s;
    @(negedge clk);
    @(negedge clk); chk("state_setup", 32'(st), 32'd1);
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk); chk("state_phase", 32'(st), w ? 32'd2 : 32'd3);
    waits = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (ready === 1'b1) done = 1;
      else waits++;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    else chk("wait_cycles", 32'(waits), 32'd1);
    @(posedge clk); #1;
    sel = 1'b0; en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sel = 0; en = 0; wr = 0; addr = '0; wdata = '0; strb = '0;
    b_sel = 0; b_en = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_strb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", 32'(rd), 32'h12);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_slverr", 32'(err), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    apb_xfer(1'b0, 8'd3, '0, '0, 1'b0, DW'('h12));
    apb_xfer(1'b1, 8'h05, DW'('hA5), '1, 1'b0, '0);
    apb_xfer(1'b0, 8'h05, '0, '0, 1'b0, DW'('hA5));
    apb_xfer(1'b1, 8'h20, DW'('h3C), '1, 1'b1, '0);
    apb_xfer(1'b0, 8'h20, '0, '0, 1'b1, '0);
    for (int i = 0; i < 16; i++)
      apb_xfer(1'b0, AW'(i), '0, '0, 1'b0, (i == 5) ? DW'('hA5) : DW'('h12));

    // Abort: drop p_sel during W_PHASE before completion.
    @(posedge clk); #1;
    sel = 1; en = 0; wr = 1; addr = 8'd2; wdata = DW'('h55); strb = '1;
    repeat (2) @(posedge clk); #1 en = 1;
    @(negedge clk); chk("abort_phase", 32'(st), 32'd2);
    @(posedge clk); #1 sel = 0; en = 0;
    @(posedge clk); @(negedge clk); chk("abort_idle", 32'(st), 32'd0);
    apb_xfer(1'b0, 8'd2, '0, '0, 1'b0, DW'('h12));

    // Reset in the middle of a write phase.
    @(posedge clk); #1;
    sel = 1; en = 0; wr = 1; addr = 8'd1; wdata = DW'('h77); strb = '1;
    repeat (2) @(posedge clk); #1 en = 1; rstn = 0;
    @(posedge clk); @(negedge clk);
    chk("midrst_state", 32'(st), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    #1 rstn = 1; sel = 0; en = 0;
    apb_xfer(1'b0, 8'd1, '0, '0, 1'b0, DW'('h12));
    apb_xfer(1'b0, 8'd5, '0, '0, 1'b0, DW'('h12));

    // Zero-wait instance: back-to-back read then write with p_sel held.
    @(posedge clk); #1;
    b_sel = 1; b_en = 0; b_wr = 0; b_addr = 8'd3; b_strb = '1;
    repeat (2) @(posedge clk); #1 b_en = 1;
    @(negedge clk);
    chk("w0_rstate", 32'(b_st), 32'd3);
    chk("w0_rready", 32'(b_ready), 32'd1);
    chk("w0_rdata", 32'(b_rd), 32'h12);
    @(posedge clk); #1 b_en = 0; b_wr = 1; b_addr = 8'd4; b_wdata = DW'('h9A);
    @(negedge clk); chk("w0_setup", 32'(b_st), 32'd1);
    @(posedge clk); #1 b_en = 1;
    @(negedge clk);
    chk("w0_wstate", 32'(b_st), 32'd2);
    chk("w0_wready", 32'(b_ready), 32'd1);
    chk("w0_werr", 32'(b_err), 32'd0);
    @(posedge clk); #1 b_sel = 0; b_en = 0;
    @(posedge clk); #1 b_sel = 1; b_wr = 0;
    repeat (2) @(posedge clk); #1 b_en = 1;
    @(negedge clk);
    chk("w0_rback_ready", 32'(b_ready), 32'd1);
    chk("w0_rback_data", 32'(b_rd), 32'h9A);
    @(posedge clk); #1 b_sel = 0; b_en = 0;

`ifdef APB_PSTRB_EN
    apb_xfer(1'b1, 8'd6, 16'hBEEF, 2'b10, 1'b0, '0);
    apb_xfer(1'b0, 8'd6, '0, '0, 1'b0, 16'hBE12);
    apb_xfer(1'b1, 8'd6, 16'h1234, 2'b00, 1'b0, '0);
    apb_xfer(1'b0, 8'd6, '0, 2'b11, 1'b0, 16'hBE12);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
